// File: rtl/nvram_upload_ctrl.sv
// nvram_upload_ctrl: core-to-HPS ioctl upload of the battery-backed CMOS RAM.
// Serves host reads from the CMOS read port. With NVRAM_AUTOSAVE_EN defined,
// it also watches CPU CMOS writes and requests an upload once writes have
// settled for SETTLE_FRAMES frames. The default build (macro undefined) has
// host-initiated uploads only.
module nvram_upload_ctrl #(
  parameter logic [7:0]  INDEX         = 8'd4,
  parameter int unsigned AW            = 10,
  parameter int unsigned DW            = 4,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned SETTLE_FRAMES = 60,
  parameter int unsigned REQ_TIMEOUT   = 64
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vblank,
  input  logic          cmos_we,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [16:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          ioctl_upload_req,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic [16:0] DEPTH_A  = 17'(DEPTH);
  localparam int unsigned LW       = 2;
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT);

`ifdef NVRAM_AUTOSAVE_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    REQ    = 3'd2,
    XFER   = 3'd3,
    DONE   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;
`endif

  state_t        state_q;
  state_t        state_d;
  logic          sel;
  logic          in_range;
  logic          rd_fire;
  logic [LW-1:0] lat_cnt;

  assign sel      = ioctl_upload && (ioctl_index == INDEX);
  assign in_range = ioctl_addr < DEPTH_A;
  // A host read is accepted only in XFER and only when no read is in flight.
  assign rd_fire  = (state_q == XFER) && sel && ioctl_rd && !ioctl_wait;
  // The RAM port is driven in the strobe cycle so data returns RD_LAT+1 after ioctl_rd.
  assign ram_rd   = rd_fire && in_range;
  assign ram_addr = ram_rd ? ioctl_addr[AW-1:0] : '0;
  assign busy     = (state_q != IDLE);

  // Read datapath: latch RAM data RD_LAT cycles after the read, or 0xFF out of range.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      lat_cnt    <= '0;
    end else if (ioctl_wait) begin
      if (lat_cnt == LW'(1)) begin
        ioctl_din  <= 8'(ram_q);
        ioctl_wait <= 1'b0;
        lat_cnt    <= '0;
      end else begin
        lat_cnt <= lat_cnt - LW'(1);
      end
    end else if (rd_fire) begin
      if (in_range) begin
        ioctl_wait <= 1'b1;
        lat_cnt    <= LAT_INIT;
      end else begin
        ioctl_din <= 8'hFF;
      end
    end
  end

`ifdef NVRAM_AUTOSAVE_EN
  localparam int unsigned CNT_MAX = (SETTLE_FRAMES > REQ_TIMEOUT) ? SETTLE_FRAMES : REQ_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic          vb_q;
  logic          vb_rise;
  logic          dirty_q;
  logic          dirty_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign vb_rise = vblank && !vb_q;

  // State, shared frame counter (settle / request timeout), dirty flag and vblank edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dirty_q <= 1'b0;
      vb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dirty_q <= dirty_d;
      vb_q    <= vblank;
    end
  end

  // Next state: host upload wins over autosave; a CPU write restarts the settle period.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dirty_d          = dirty_q;
    ioctl_upload_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel) begin
          state_d = XFER;
          dirty_d = cmos_we;
        end else if (cmos_we) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (sel) begin
          state_d = XFER;
          dirty_d = cmos_we;
        end else if (cmos_we) begin
          cnt_d = '0;
        end else if (vb_rise) begin
          if (cnt_q >= CW'(SETTLE_FRAMES - 1)) begin
            state_d = REQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      REQ: begin
        ioctl_upload_req = !sel;
        if (sel) begin
          state_d = XFER;
          dirty_d = cmos_we;
        end else if (cmos_we) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (vb_rise) begin
          if (cnt_q >= CW'(REQ_TIMEOUT - 1)) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      XFER: begin
        if (cmos_we) begin
          dirty_d = 1'b1;
        end
        if (!sel && !ioctl_wait) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (dirty_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
          dirty_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`else
  logic unused_autosave;

  assign unused_autosave  = vblank ^ cmos_we;
  assign ioctl_upload_req = 1'b0;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: host-initiated upload only.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (!sel && !ioctl_wait) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end
`endif

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Bench for nvram_upload_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share stimulus;
// read completions and request rises are checked by a monitor against queued expectations.
module tb_nvram_upload_ctrl;

`ifdef NVRAM_AUTOSAVE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic [7:0] din;
    int         lat;
  } rd_exp_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vblank;
  logic        cmos_we;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [16:0] ioctl_addr;

  logic [7:0]  din_a, din_b;
  logic        wt_a, wt_b;
  logic        req_a, req_b;
  logic [9:0]  raddr_a, raddr_b;
  logic        rrd_a, rrd_b;
  logic [3:0]  rq_a, rq_b;
  logic        bsy_a, bsy_b;

  logic [3:0]  mem [1024];
  logic [3:0]  s0_b, s1_b;

  int          checks   = 0;
  int          failures = 0;
  int          frame_no = 0;
  rd_exp_t     rd_q  [2][$];
  int          req_q [2][$];
  bit          act      [2];
  int          wcnt     [2];
  logic        req_prev [2];

  always #5 clk_sys = ~clk_sys;

  nvram_upload_ctrl #(.RD_LAT(1)) u_dut_l1 (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank), .cmos_we(cmos_we),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din_a), .ioctl_wait(wt_a),
    .ioctl_upload_req(req_a), .ram_addr(raddr_a), .ram_rd(rrd_a), .ram_q(rq_a),
    .busy(bsy_a)
  );

  nvram_upload_ctrl #(.RD_LAT(3)) u_dut_l3 (
    .clk_sys(clk_sys), .reset(reset), .vblank(vblank), .cmos_we(cmos_we),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din_b), .ioctl_wait(wt_b),
    .ioctl_upload_req(req_b), .ram_addr(raddr_b), .ram_rd(rrd_b), .ram_q(rq_b),
    .busy(bsy_b)
  );

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    mem[10'h000] = 4'h5;
    mem[10'h001] = 4'hC;
    mem[10'h155] = 4'h3;
    mem[10'h3FF] = 4'hA;
  end

  // CMOS read-port models with one and three cycles of latency.
  always_ff @(posedge clk_sys) begin
    rq_a <= mem[raddr_a];
    s0_b <= mem[raddr_b];
    s1_b <= s0_b;
    rq_b <= s1_b;
  end

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic mon_step(input int d, input logic w, input logic [7:0] dv, input logic rq_now);
    rd_exp_t e;
    if (reset) begin
      act[d] = 1'b0;
    end else if (act[d]) begin
      if (w) begin
        wcnt[d]++;
        if (wcnt[d] > 8) begin
          check($sformatf("rd_wait_stuck_d%0d", d), 32'(w), 32'd0);
          void'(rd_q[d].pop_front());
          act[d] = 1'b0;
        end
      end else begin
        e = rd_q[d].pop_front();
        check($sformatf("rd_din_d%0d", d), 32'(dv), 32'(e.din));
        check($sformatf("rd_wait_cycles_d%0d", d), 32'(wcnt[d]), 32'(e.lat));
        act[d] = 1'b0;
      end
    end else if (ioctl_rd && rd_q[d].size() > 0) begin
      act[d]  = 1'b1;
      wcnt[d] = 0;
    end
    if (rq_now === 1'b1 && req_prev[d] !== 1'b1) begin
      if (req_q[d].size() == 0) check($sformatf("req_rise_unexpected_d%0d", d), 32'(rq_now), 32'd0);
      else check($sformatf("req_rise_frame_d%0d", d), 32'(frame_no), 32'(req_q[d].pop_front()));
    end
    req_prev[d] = rq_now;
  endtask

  // Monitor: compares each read completion and each request rise against the queues.
  always @(negedge clk_sys) begin
    mon_step(0, wt_a, din_a, req_a);
    mon_step(1, wt_b, din_b, req_b);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic frame(input bit we);
    frame_no++;
    vblank  = 1'b1;
    cmos_we = we;
    tick();
    vblank  = 1'b0;
    cmos_we = 1'b0;
    ticks(3);
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0);
  endtask

  task automatic push_req(input int f);
    if (AUTO) begin
      req_q[0].push_back(f);
      req_q[1].push_back(f);
    end
  endtask

  task automatic check_req(input string name, input logic exp_v);
    check({name, "_l1"}, 32'(req_a), 32'(exp_v));
    check({name, "_l3"}, 32'(req_b), 32'(exp_v));
  endtask

  task automatic check_busy(input string name, input logic exp_v);
    check({name, "_l1"}, 32'(bsy_a), 32'(exp_v));
    check({name, "_l3"}, 32'(bsy_b), 32'(exp_v));
  endtask

  task automatic check_zero(input string name);
    check({name, "_din_l1"}, 32'(din_a), 32'd0);
    check({name, "_din_l3"}, 32'(din_b), 32'd0);
    check({name, "_wait_l1"}, 32'(wt_a), 32'd0);
    check({name, "_wait_l3"}, 32'(wt_b), 32'd0);
    check({name, "_ramrd_l1"}, 32'(rrd_a), 32'd0);
    check({name, "_ramrd_l3"}, 32'(rrd_b), 32'd0);
    check({name, "_ramaddr_l1"}, 32'(raddr_a), 32'd0);
    check({name, "_ramaddr_l3"}, 32'(raddr_b), 32'd0);
    check_req({name, "_req"}, 1'b0);
    check_busy({name, "_busy"}, 1'b0);
  endtask

  task automatic host_read(input logic [16:0] addr, input logic [7:0] exp_din,
                           input bit in_rng, input bit extra);
    rd_exp_t    e;
    logic [9:0] ea;
    e.din = exp_din;
    e.lat = in_rng ? 1 : 0;
    rd_q[0].push_back(e);
    e.lat = in_rng ? 3 : 0;
    rd_q[1].push_back(e);
    ea = in_rng ? addr[9:0] : 10'h000;
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    #2;
    check("ram_rd_l1", 32'(rrd_a), 32'(in_rng));
    check("ram_rd_l3", 32'(rrd_b), 32'(in_rng));
    check("ram_addr_l1", 32'(raddr_a), 32'(ea));
    check("ram_addr_l3", 32'(raddr_b), 32'(ea));
    tick();
    ioctl_rd = 1'b0;
    if (extra) begin
      ioctl_rd   = 1'b1;
      ioctl_addr = 17'h00001;
      #2;
      check("ram_rd_ignored_l1", 32'(rrd_a), 32'd0);
      check("ram_rd_ignored_l3", 32'(rrd_b), 32'd0);
      tick();
      ioctl_rd = 1'b0;
    end
    for (int i = 0; i < 10 && (wt_a || wt_b); i++) tick();
    ticks(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    vblank       = 1'b0;
    cmos_we      = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = 17'h0;
    ticks(3);
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Wrong index does not select; correct index enters XFER.
    ioctl_upload = 1'b1;
    ioctl_index  = 8'd3;
    ticks(2);
    check_busy("busy_wrong_index", 1'b0);
    ioctl_index = 8'd4;
    tick();
    check_busy("busy_xfer", 1'b1);

    host_read(17'h003FF, 8'h0A, 1'b1, 1'b1);
    host_read(17'h00000, 8'h05, 1'b1, 1'b0);
    host_read(17'h00001, 8'h0C, 1'b1, 1'b0);
    host_read(17'h00400, 8'hFF, 1'b0, 1'b0);
    ticks(3);
    check("din_hold_l1", 32'(din_a), 32'h0FF);
    check("din_hold_l3", 32'(din_b), 32'h0FF);
    host_read(17'h1FFFF, 8'hFF, 1'b0, 1'b0);
    host_read(17'h00155, 8'h03, 1'b1, 1'b0);

    ioctl_upload = 1'b0;
    tick();
    check_busy("busy_done", 1'b1);
    tick();
    check_busy("busy_idle", 1'b0);
    check_req("req_idle", 1'b0);

    // Autosave: one write, 60 quiet frames, then request; host select drops it at once.
    frame_no = 0;
    cmos_we  = 1'b1;
    tick();
    cmos_we  = 1'b0;
    tick();
    check_busy("busy_settle", AUTO);
    push_req(60);
    frames(60);
    check_req("req_after_settle", AUTO);
    ticks(3);
    check_req("req_level_hold", AUTO);
    ioctl_upload = 1'b1;
    #1;
    check_req("req_drop_on_sel", 1'b0);
    tick();
    check_busy("busy_xfer_req", 1'b1);
    host_read(17'h00155, 8'h03, 1'b1, 1'b0);
    ioctl_upload = 1'b0;
    ticks(2);
    check_busy("busy_idle_after_save", 1'b0);

    // Settle restart: writes at frames 0, 30 and 59 (the last two with vblank rising).
    frame_no = 0;
    cmos_we  = 1'b1;
    tick();
    cmos_we  = 1'b0;
    tick();
    frames(29);
    frame(1'b1);
    frames(28);
    frame(1'b1);
    frames(59);
    check_req("req_not_early", 1'b0);
    push_req(119);
    frame(1'b0);
    check_req("req_at_119", AUTO);

    // Timeout: no host for 64 frames returns to SETTLE, then re-requests 60 frames later.
    frames(63);
    check_req("req_before_timeout", AUTO);
    frame(1'b0);
    check_req("req_timeout_drop", 1'b0);
    check_busy("busy_timeout_settle", AUTO);
    push_req(243);
    frames(60);
    check_req("req_retry", AUTO);

    // Select and write together in REQ: upload, then DONE goes back to SETTLE.
    ioctl_upload = 1'b1;
    cmos_we      = 1'b1;
    #1;
    check_req("req_drop_sel_we", 1'b0);
    tick();
    cmos_we = 1'b0;
    check_busy("busy_xfer_sel_we", 1'b1);
    host_read(17'h00001, 8'h0C, 1'b1, 1'b0);
    ioctl_upload = 1'b0;
    ticks(2);
    check_busy("busy_dirty_settle", AUTO);
    frame_no = 0;
    push_req(60);
    frames(60);
    check_req("req_after_dirty", AUTO);

    // CPU write while requesting drops the request.
    cmos_we = 1'b1;
    tick();
    cmos_we = 1'b0;
    check_req("req_drop_on_we", 1'b0);
    check_busy("busy_we_in_req", AUTO);

    // Write in the middle of an upload.
    ioctl_upload = 1'b1;
    ticks(2);
    cmos_we = 1'b1;
    tick();
    cmos_we = 1'b0;
    host_read(17'h003FF, 8'h0A, 1'b1, 1'b0);
    ioctl_upload = 1'b0;
    frame_no = 0;
    push_req(60);
    ticks(2);
    frames(60);
    check_req("req_after_xfer_write", AUTO);
    ioctl_upload = 1'b1;
    tick();
    ioctl_upload = 1'b0;
    ticks(2);
    check_busy("busy_idle_clean", 1'b0);

    // Reset in the middle of a read abandons it.
    ioctl_upload = 1'b1;
    tick();
    ioctl_addr = 17'h003FF;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("wait_before_reset_l1", 32'(wt_a), 32'd1);
    check("wait_before_reset_l3", 32'(wt_b), 32'd1);
    reset = 1'b1;
    tick();
    check_zero("reset_mid_read");
    reset = 1'b0;
    ticks(4);
    check("abandoned_wait_l1", 32'(wt_a), 32'd0);
    check("abandoned_wait_l3", 32'(wt_b), 32'd0);
    check("abandoned_din_l1", 32'(din_a), 32'd0);
    check("abandoned_din_l3", 32'(din_b), 32'd0);
    ioctl_upload = 1'b0;
    ticks(3);

    check("rd_queue_empty", 32'(rd_q[0].size() + rd_q[1].size()), 32'd0);
    check("req_queue_empty", 32'(req_q[0].size() + req_q[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
